// File: rtl/decoder_rr_scheduler_5to32.sv
// Round-robin scheduler that shares one 5-to-32 one-hot decoder between NREQ requesters.
// The granted index is decoded (single or pair mode) into a registered select vector held HOLD_CYCLES cycles.
module decoder_rr_scheduler_5to32 #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NREQ-1:0]                       req,
  input  logic [5*NREQ-1:0]                     addr,
  input  logic [NREQ-1:0]                       spec,
  output logic [NREQ-1:0]                       gnt,
  output logic [31:0]                           out,
  output logic                                  out_valid,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner,
  output logic                                  busy
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [NREQ-1:0] gnt_d;
  logic [DW-1:0]   out_d;
  logic            valid_d;
  logic [OW-1:0]   owner_d;
  logic            busy_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              pick_found;
  logic [OW:0]       pick_sum;
  logic [OW-1:0]     pick_k;
  logic [AW-1:0]     sel_addr;
  logic              sel_spec;
  logic [DW-1:0]     dec_onehot;
  logic [DW-1:0]     dec_vec;

  // Rotate requests so bit 0 is the requester at rr_q, then take the lowest set bit.
  always_comb begin
    req_dbl    = {req, req};
    req_rot    = NREQ'(req_dbl >> rr_q);
    pick_found = 1'b0;
    pick_sum   = '0;
    pick_k     = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!pick_found && req_rot[j]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_q} + (OW+1)'(j);
      end
    end
    if (pick_sum >= (OW+1)'(NREQ)) begin
      pick_sum = pick_sum - (OW+1)'(NREQ);
    end
    pick_k = OW'(pick_sum);
  end

  // Fetch the winner's address/mode and decode it.
  always_comb begin
    sel_addr = '0;
    sel_spec = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_k == OW'(i)) begin
        sel_addr = addr[i*AW +: AW];
        sel_spec = spec[i];
      end
    end
    dec_onehot = DW'(1) << sel_addr;
    dec_vec    = sel_spec ? (dec_onehot | (dec_onehot << 1)) : dec_onehot;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    gnt_d   = '0;
    out_d   = out;
    valid_d = out_valid;
    owner_d = owner;
    busy_d  = busy;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gnt_d   = NREQ'(1) << pick_k;
          owner_d = pick_k;
          out_d   = dec_vec;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          rr_d    = (pick_k == OW'(NREQ-1)) ? '0 : pick_k + OW'(1);
          hold_d  = CW'(HOLD_CYCLES-1);
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (hold_q == '0) begin
          out_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      owner     <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      out       <= out_d;
      out_valid <= valid_d;
      owner     <= owner_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_decoder_rr_scheduler_5to32.sv
// Bench for decoder_rr_scheduler_5to32: two instances (hold 1 and hold 3) checked every cycle
// against a grant-timestamp reference model, plus directed scenarios and random traffic.
module tb_decoder_rr_scheduler_5to32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_v  [2];
  logic [5*N-1:0] addr_v [2];
  logic [N-1:0]   spec_v [2];
  logic [N-1:0]   gnt_v  [2];
  logic [31:0]    out_v  [2];
  logic           val_v  [2];
  logic [1:0]     own_v  [2];
  logic           busy_v [2];

  decoder_rr_scheduler_5to32 #(.NREQ(N), .HOLD_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .addr(addr_v[0]), .spec(spec_v[0]),
    .gnt(gnt_v[0]), .out(out_v[0]), .out_valid(val_v[0]), .owner(own_v[0]), .busy(busy_v[0]));

  decoder_rr_scheduler_5to32 #(.NREQ(N), .HOLD_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .addr(addr_v[1]), .spec(spec_v[1]),
    .gnt(gnt_v[1]), .out(out_v[1]), .out_valid(val_v[1]), .owner(own_v[1]), .busy(busy_v[1]));

  int tests = 0;
  int fails = 0;
  longint cyc = 0;

  // Model: each instance remembers when (edge number) and to whom its last grant went.
  bit          m_has   [2];
  longint      m_last  [2];
  int          m_rr    [2];
  int          m_owner [2];
  logic [31:0] m_out   [2];
  int          waitc   [2][N];
  int          grants  [2][N];

  function automatic int hold_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] ref_dec(int a, bit s);
    longint v;
    v = longint'(1) << a;
    if (s) v = v | (v * 2);
    return v[31:0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_has[i] = 1'b0; m_last[i] = 0; m_rr[i] = 0; m_owner[i] = 0; m_out[i] = '0;
      for (int j = 0; j < N; j++) waitc[i][j] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit idle;
      int k;
      idle = !m_has[i] || (cyc > m_last[i] + longint'(hold_of(i)));
      for (int j = 0; j < N; j++) if (!req_v[i][j]) waitc[i][j] = 0;
      if (idle && req_v[i] != '0) begin
        k = -1;
        for (int s = 0; s < N; s++) begin
          if (k < 0 && req_v[i][(m_rr[i] + s) % N]) k = (m_rr[i] + s) % N;
        end
        chk($sformatf("fair%0d_req%0d", i, k), 32'(waitc[i][k] <= N-1), 32'd1);
        for (int j = 0; j < N; j++) if (j != k && req_v[i][j]) waitc[i][j]++;
        waitc[i][k] = 0;
        grants[i][k]++;
        m_has[i]   = 1'b1;
        m_last[i]  = cyc;
        m_owner[i] = k;
        m_out[i]   = ref_dec(int'(addr_v[i][5*k +: 5]), spec_v[i][k]);
        m_rr[i]    = (k + 1) % N;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit          e_val;
      logic [N-1:0] e_gnt;
      e_val = m_has[i] && (cyc - m_last[i] < longint'(hold_of(i)));
      e_gnt = (m_has[i] && cyc == m_last[i]) ? N'(1) << m_owner[i] : '0;
      chk($sformatf("gnt%0d", i),   32'(gnt_v[i]),  32'(e_gnt));
      chk($sformatf("valid%0d", i), 32'(val_v[i]),  32'(e_val));
      chk($sformatf("busy%0d", i),  32'(busy_v[i]), 32'(e_val));
      chk($sformatf("out%0d", i),   out_v[i],       e_val ? m_out[i] : 32'h0);
      chk($sformatf("owner%0d", i), 32'(own_v[i]),  32'(m_owner[i]));
    end
  endtask

  // One clock: model follows the edge, outputs compared mid-low-phase, granted requesters drop req.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_all();
    for (int i = 0; i < 2; i++) req_v[i] = req_v[i] & ~gnt_v[i];
  endtask

  initial begin
    int          av [3];
    logic [31:0] ev [3];
    int          vcnt;
    int          gcnt;
    av = '{0, 31, 15};
    ev = '{32'h0000_0003, 32'h8000_0000, 32'h0001_8000};
    for (int i = 0; i < 2; i++) begin
      req_v[i] = '0; addr_v[i] = '0; spec_v[i] = '0;
      for (int j = 0; j < N; j++) grants[i][j] = 0;
    end
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset in the middle of a hold-3 drive of 0x100.
    req_v[1] = 4'b0001;
    addr_v[1][4:0] = 5'd8;
    tick();
    chk("t1_out_before_reset", out_v[1], 32'h0000_0100);
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t1_out_async", out_v[1], 32'h0);
    chk("t1_busy_async", 32'(busy_v[1]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting, addrs 1..4: grants 0,1,2,3 every other cycle on the hold-1 instance.
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 4'b1111; spec_v[i] = '0;
      addr_v[i] = {5'd4, 5'd3, 5'd2, 5'd1};
    end
    for (int t = 0; t < 16; t++) begin
      tick();
      if (t == 0) chk("t1_first_gnt_hold3", 32'(gnt_v[1]), 32'h1);
      if (t < 8 && t % 2 == 0) begin
        chk($sformatf("t4_owner_%0d", t), 32'(own_v[0]), 32'(t / 2));
        chk($sformatf("t4_out_%0d", t), out_v[0], 32'h1 << (t / 2 + 1));
        chk($sformatf("t4_gnt_%0d", t), 32'(gnt_v[0]), 32'h1 << (t / 2));
      end
    end

    // Single request, addr 5, hold 1.
    req_v[0] = 4'b0001; addr_v[0][4:0] = 5'd5; spec_v[0] = '0;
    tick();
    chk("t2_gnt", 32'(gnt_v[0]), 32'h1);
    chk("t2_out", out_v[0], 32'h0000_0020);
    tick();
    chk("t2_out_after", out_v[0], 32'h0);
    chk("t2_busy_after", 32'(busy_v[0]), 32'h0);

    // Pair mode at the boundaries and in the middle.
    for (int n = 0; n < 3; n++) begin
      req_v[0] = 4'b0001; spec_v[0] = 4'b0001; addr_v[0][4:0] = 5'(av[n]);
      tick();
      chk($sformatf("t3_pair_a%0d", av[n]), out_v[0], ev[n]);
      tick();
    end
    spec_v[0] = '0;

    // Hold 3 with a second request raised mid-drive.
    vcnt = 0; gcnt = 0;
    req_v[1] = 4'b0001; addr_v[1] = {5'd0, 5'd7, 5'd0, 5'd6}; spec_v[1] = '0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (t < 4) begin
        vcnt += int'(val_v[1]);
        gcnt += (gnt_v[1] != '0) ? 1 : 0;
      end
      if (t == 0) req_v[1] = req_v[1] | 4'b0100;
      if (t == 4) chk("t5_second_gnt", 32'(gnt_v[1]), 32'h4);
    end
    chk("t5_valid_cycles", 32'(vcnt), 32'd3);
    chk("t5_gnt_cycles", 32'(gcnt), 32'd1);

    // Round-robin wrap: 3, then 1 from 1010, then 3.
    req_v[0] = 4'b1000; addr_v[0] = {5'd9, 5'd0, 5'd2, 5'd0};
    tick();
    chk("t6_owner3", 32'(own_v[0]), 32'd3);
    tick();
    req_v[0] = 4'b1010;
    tick();
    chk("t6_owner1", 32'(own_v[0]), 32'd1);
    tick();
    tick();
    chk("t6_owner3b", 32'(own_v[0]), 32'd3);
    tick();

    // Random traffic; requesters keep addr/spec stable while pending.
    for (int i = 0; i < 2; i++) for (int j = 0; j < N; j++) grants[i][j] = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < N; j++) begin
          if (!req_v[i][j] && $urandom_range(0, 2) == 0) begin
            req_v[i][j] = 1'b1;
            addr_v[i][5*j +: 5] = 5'($urandom_range(0, 31));
            spec_v[i][j] = 1'($urandom_range(0, 1));
          end
        end
      end
      tick();
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("starve%0d_req%0d", i, j), 32'(grants[i][j] > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
